// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule engine.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int NR      = 10;
   localparam int SCHED_W = 1408;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = p ^ (aa & {8{b[i]}});
         aa = gf_xtime(aa);
      end
      return p;
   endfunction

   // Out-of-range counts select no entry and yield zero.
   function automatic logic [7:0] rcon_f(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 1; i <= NR; i++) begin
         v = v | (RCON[i] & {8{r == 4'(i)}});
      end
      return v;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (as a^254) followed by the affine map.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] s
);

   logic [7:0] p2_s, p4_s, p8_s, p16_s, p32_s, p64_s, p128_s;
   logic [7:0] inv_s;

   // Square-and-multiply chain for the multiplicative inverse, then affine transform
   always_comb begin
      p2_s   = gf_mul(a, a);
      p4_s   = gf_mul(p2_s, p2_s);
      p8_s   = gf_mul(p4_s, p4_s);
      p16_s  = gf_mul(p8_s, p8_s);
      p32_s  = gf_mul(p16_s, p16_s);
      p64_s  = gf_mul(p32_s, p32_s);
      p128_s = gf_mul(p64_s, p64_s);
      inv_s  = gf_mul(gf_mul(gf_mul(p2_s, p4_s), gf_mul(p8_s, p16_s)),
                      gf_mul(gf_mul(p32_s, p64_s), p128_s));
      s = inv_s
        ^ {inv_s[6:0], inv_s[7]}
        ^ {inv_s[5:0], inv_s[7:6]}
        ^ {inv_s[4:0], inv_s[7:5]}
        ^ {inv_s[3:0], inv_s[7:4]}
        ^ 8'h63;
   end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion, one round key per clock.
// Optional last-key cache enabled by defining AES_KEYSCHED_CACHE_EN.
module aes_key_schedule
   import aes_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 start,
   input  logic [127:0]         key_in,
   output logic                 busy,
   output logic                 done,
   output logic [SCHED_W-1:0]   schedule
);

   state_e               state_r;
   logic [3:0]           rcnt_r;
   logic                 busy_r;
   logic                 done_r;
   logic [SCHED_W-1:0]   schedule_r;

   logic [127:0]         prev_rk_s;
   logic [31:0]          rot_s;
   logic [31:0]          sub_s;
   logic [31:0]          t_s;
   logic [7:0]           rcon_s;
   logic [31:0]          w0_s, w1_s, w2_s, w3_s;
   logic                 cache_hit_s;

`ifdef AES_KEYSCHED_CACHE_EN
   logic                 key_valid_r;
   logic [127:0]         last_key_r;
   assign cache_hit_s = key_valid_r && (key_in == last_key_r);
`else
   assign cache_hit_s = 1'b0;
`endif

   // AND-OR mux selecting round key rcnt-1 from the schedule
   always_comb begin
      prev_rk_s = '0;
      for (int i = 0; i < NR; i++) begin
         prev_rk_s = prev_rk_s
                   | ({128{rcnt_r == 4'(i + 1)}} & schedule_r[SCHED_W-1-128*i -: 128]);
      end
   end

   assign rcon_s = rcon_f(rcnt_r);
   assign rot_s  = {prev_rk_s[23:0], prev_rk_s[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .a (rot_s[8*b +: 8]),
         .s (sub_s[8*b +: 8])
      );
   end

   assign t_s  = sub_s ^ {rcon_s, 24'h000000};
   assign w0_s = prev_rk_s[127:96] ^ t_s;
   assign w1_s = prev_rk_s[95:64]  ^ w0_s;
   assign w2_s = prev_rk_s[63:32]  ^ w1_s;
   assign w3_s = prev_rk_s[31:0]   ^ w2_s;

   // Control FSM with registered busy/done and the round-key store
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r    <= IDLE;
         rcnt_r     <= 4'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         schedule_r <= '0;
`ifdef AES_KEYSCHED_CACHE_EN
         key_valid_r <= 1'b0;
         last_key_r  <= 128'h0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               if (start && cache_hit_s) begin
                  state_r <= DONE;
               end else if (start) begin
                  schedule_r[SCHED_W-1 -: 128] <= key_in;
                  rcnt_r  <= 4'd1;
                  busy_r  <= 1'b1;
                  state_r <= EXPAND;
`ifdef AES_KEYSCHED_CACHE_EN
                  last_key_r  <= key_in;
                  key_valid_r <= 1'b0;
`endif
               end
            end
            EXPAND: begin
               if (!start) begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
`ifdef AES_KEYSCHED_CACHE_EN
                  key_valid_r <= 1'b0;
`endif
               end else begin
                  for (int i = 1; i <= NR; i++) begin
                     if (rcnt_r == 4'(i)) begin
                        schedule_r[SCHED_W-1-128*i -: 128] <= {w0_s, w1_s, w2_s, w3_s};
                     end
                  end
                  if (rcnt_r == 4'(NR)) begin
                     busy_r  <= 1'b0;
                     state_r <= DONE;
`ifdef AES_KEYSCHED_CACHE_EN
                     key_valid_r <= 1'b1;
`endif
                  end else begin
                     rcnt_r <= rcnt_r + 4'd1;
                  end
               end
            end
            DONE: begin
               busy_r <= 1'b0;
               if (start) begin
                  done_r <= 1'b1;
               end else begin
                  done_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign schedule = schedule_r;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: known-answer table, corner sequences, random keys.
module tb_aes_key_schedule;

   logic           Clk = 1'b0;
   logic           Reset;
   logic           start;
   logic [127:0]   key_in;
   logic           busy;
   logic           done;
   logic [1407:0]  schedule;

   int n_pass   = 0;
   int n_checks = 0;

   logic [7:0] sb_t [256];

`ifdef AES_KEYSCHED_CACHE_EN
   localparam int HIT_LAT  = 1;
   localparam int HIT_BUSY = 0;
`else
   localparam int HIT_LAT  = 11;
   localparam int HIT_BUSY = 10;
`endif

   typedef struct {
      logic [127:0] key;
      logic [127:0] rk1;
      logic [127:0] rk10;
   } vec_t;

   vec_t vecs [3];

   aes_key_schedule dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .done     (done),
      .schedule (schedule)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] xt(input logic [7:0] a);
      return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
      return (v << k) | (v >> (8 - k));
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [1407:0] expand_m(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc = 8'h01;
      logic [1407:0] s;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) s[1407-32*i -: 32] = w[i];
      return s;
   endfunction

   function automatic logic [127:0] rk(input logic [1407:0] s, input int i);
      return s[1407-128*i -: 128];
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_wide(input string name, input logic [1407:0] got, input logic [1407:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic run_expand(input logic [127:0] key, output int lat, output int bcnt, output int ovl);
      key_in = key;
      start  = 1'b1;
      lat    = -1;
      bcnt   = 0;
      ovl    = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (busy) bcnt++;
         if (busy && done) ovl++;
         if (done) begin
            lat = k - 1;
            break;
         end
      end
   endtask

   task automatic release_start();
      start = 1'b0;
      step();
      chk_int("done_fall", int'(done), 0);
   endtask

   task automatic full_check(input string tag, input logic [127:0] key, input int exp_lat, input int exp_busy);
      int lat, bcnt, ovl;
      run_expand(key, lat, bcnt, ovl);
      chk_int({tag, "_lat"}, lat, exp_lat);
      chk_int({tag, "_busy_cycles"}, bcnt, exp_busy);
      chk_int({tag, "_overlap"}, ovl, 0);
      chk_wide({tag, "_sched"}, schedule, expand_m(key));
   endtask

   initial begin
      logic [127:0] ka, k1, k2;
      int lat, bcnt, ovl, nd;

      for (int i = 0; i < 256; i++) sb_t[i] = sbox_m(8'(i));
      vecs[0] = '{128'h0, 128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                  128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      ka = vecs[2].key;

      // reset with start requested: reset must win
      Reset  = 1'b1;
      start  = 1'b1;
      key_in = ka;
      step();
      step();
      chk_int("rst_busy", int'(busy), 0);
      chk_int("rst_done", int'(done), 0);
      chk_wide("rst_sched", schedule, '0);
      start = 1'b0;
      Reset = 1'b0;
      step();

      // known-answer table
      for (int i = 0; i < 3; i++) begin
         run_expand(vecs[i].key, lat, bcnt, ovl);
         chk_int("kat_lat", lat, 11);
         chk_int("kat_busy_cycles", bcnt, 10);
         chk_int("kat_overlap", ovl, 0);
         chk_wide("kat_rk0", {1280'h0, rk(schedule, 0)}, {1280'h0, vecs[i].key});
         chk_wide("kat_rk1", {1280'h0, rk(schedule, 1)}, {1280'h0, vecs[i].rk1});
         chk_wide("kat_rk10", {1280'h0, rk(schedule, 10)}, {1280'h0, vecs[i].rk10});
         chk_wide("kat_sched", schedule, expand_m(vecs[i].key));
         release_start();
      end

      // same key again right after its own expansion
      full_check("repeat", ka, HIT_LAT, HIT_BUSY);
      release_start();

      // abort at EXPAND cycle 5
      key_in = vecs[1].key;
      start  = 1'b1;
      for (int k = 0; k < 5; k++) step();
      chk_int("abort_busy_before", int'(busy), 1);
      start = 1'b0;
      step();
      chk_int("abort_busy", int'(busy), 0);
      chk_int("abort_done", int'(done), 0);
      nd = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (done || busy) nd++;
      end
      chk_int("abort_quiet", nd, 0);
      run_expand(128'h0, lat, bcnt, ovl);
      chk_int("abort_zero_lat", lat, 11);
      chk_wide("abort_zero_rk10", {1280'h0, rk(schedule, 10)}, {1280'h0, vecs[0].rk10});
      release_start();

      // key_in changes mid-expansion
      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = ~k1;
      key_in = k1;
      start  = 1'b1;
      for (int k = 0; k < 3; k++) step();
      key_in = k2;
      lat = -1;
      for (int k = 4; k <= 30; k++) begin
         step();
         if (done) begin
            lat = k - 1;
            break;
         end
      end
      chk_int("keychg_lat", lat, 11);
      chk_wide("keychg_sched", schedule, expand_m(k1));
      release_start();

      // reset at EXPAND cycle 3
      key_in = ka;
      start  = 1'b1;
      for (int k = 0; k < 3; k++) step();
      Reset = 1'b1;
      start = 1'b0;
      step();
      chk_int("midrst_busy", int'(busy), 0);
      chk_int("midrst_done", int'(done), 0);
      chk_wide("midrst_sched", schedule, '0);
      Reset = 1'b0;
      step();
      full_check("after_rst", ka, 11, 10);

      // start held high long after done
      bcnt = 0;
      nd   = 0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (busy) bcnt++;
         if (!done) nd++;
      end
      chk_int("hold_busy", bcnt, 0);
      chk_int("hold_done_low", nd, 0);
      chk_wide("hold_sched", schedule, expand_m(ka));
      release_start();

      // random keys against the reference model
      for (int r = 0; r < 6; r++) begin
         k1 = {$urandom, $urandom, $urandom, $urandom};
         full_check("rand", k1, 11, 10);
         release_start();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key expansion engine. It sits directly downstream of the Avalon-MM AES register interface: it takes the 128-bit key held in key registers 0-3 and the start register bit, then produces all 11 round keys (1408 bits) for the decryption datapath. It generates one round key per clock and reports completion with a level `done` flag, which the register interface mirrors into the done register.

## Interface
- Parameters: none (AES-128 only).
- `Clk`  in  1  system clock
- `Reset`  in  1  synchronous, active-high
- `start`  in  1  level request; bit 0 of the start register
- `key_in`  in  128  cipher key; `key_in[127:96]` is word w0 (first key byte in `[127:120]`)
- `busy`  out  1  high while expansion is in progress
- `done`  out  1  high while a complete schedule is valid and `start` remains high
- `schedule`  out  1408  round key i at `schedule[1407-128*i -: 128]`; rk0 = cipher key, rk10 at `[127:0]`

## Operation
- The FSM has three states: IDLE, EXPAND, DONE.
- **IDLE**:
  - `busy`=0, `done`=0.
  - When `start`=1 at a clock edge: load rk0 ← `key_in`, set `rcnt` ← 1, go to EXPAND.
- **EXPAND**, on each edge:
  - rk[`rcnt`] ← f(rk[`rcnt`-1], Rcon[`rcnt`]), then `rcnt`++.
  - f uses standard AES-128 expansion:
    - t = SubWord(RotWord(w3)) ^ {Rcon, 24'h0}
    - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
  - Four S-box lookups run in parallel; the whole step is combinational within one cycle.
  - When rk10 is written, go to DONE.
- **DONE**:
  - `done`=1 and `schedule` is stable.
  - When `start`=0, go to IDLE.
- `start`=0 in EXPAND aborts to IDLE. The partial schedule contents are don't-care, and `done` never asserts.
- `key_in` is sampled only on the IDLE→EXPAND edge. Later changes to `key_in` are ignored until the next request.
- `rcnt` is 4 bits and counts 1..10 only. It is never read outside the range 1..10.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.

## Timing
- Reset values:
  - state IDLE, `rcnt`=0, `busy`=0, `done`=0, `schedule`=0.
  - Reset overrides all other inputs in the same cycle.
- Latency: if `start` is seen high at edge N, then:
  - `busy` is high in cycles N+1..N+10;
  - rk1 is valid after edge N+1 and rk10 after edge N+10;
  - `done`=1 from edge N+11.
- `done` falls on the first edge at which `start`=0.
- `busy` and `done` are never high together.
- Reset asserted mid-EXPAND: back to the reset values on the next edge. No residual round keys survive.
- `start` held high across DONE never restarts an expansion. A new expansion requires `start`=0 for at least one edge (which returns the FSM to IDLE), then `start`=1.

## Configuration
- Macro: `AES_KEYSCHED_CACHE_EN`.
- When defined:
  - A valid-flag register and a 128-bit last-key register track the key of the last completed expansion.
  - An IDLE request whose `key_in` equals that key (with valid=1) goes straight to DONE. `done` asserts one edge after the request and `schedule` is untouched.
  - Reset, or an aborted expansion, clears valid.
- When undefined:
  - Every request performs the full 10-cycle expansion.
  - No last-key register is present.

## Structure
- Shared package `aes_pkg`:
  - the FSM state enum (IDLE, EXPAND, DONE);
  - the Rcon constant array [1:10];
  - widths NR=10 and SCHED_W=1408.
- One sub-module, `aes_sbox`: a combinational 8-bit forward S-box, instantiated four times for SubWord.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, `start` held high:
  - rk1 = a0fafe1788542cb123a339392a6c7605;
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `done` rises exactly 11 edges after `start` is seen.
- Same key, `start` dropped then raised again:
  - with cache: `done` rises 1 edge after the request;
  - without cache: `done` rises after 11 edges;
  - in both cases `schedule` is identical.
- `start` dropped at EXPAND cycle 5:
  - IDLE next edge, `done` stays 0, `busy`=0;
  - a subsequent all-zero key gives rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- `key_in` changed mid-expansion: the final schedule matches the originally sampled key.
- Reset asserted at EXPAND cycle 3:
  - all outputs 0 next edge, `schedule`=0;
  - with cache, the next same-key request still takes 11 edges.
- `start` held high for 50 cycles after `done`: a single expansion only; `busy` never reasserts.
